// File: rtl/rv32i_sc_core.sv
// Single-cycle RV32I core: decoder, immediate generator, register file, ALU, PC logic, data memory.
// Optional feature macro: BRANCH_UNSIGNED_EN enables BLTU/BGEU (otherwise they decode as ERROR).
module rv32i_sc_core #(
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [5:0]  cuOP,
  output logic [4:0]  regsel1,
  output logic [4:0]  regsel2,
  output logic [4:0]  w_reg,
  output logic [19:0] imm,
  output logic [31:0] immOut,
  output logic [31:0] regData1,
  output logic [31:0] regData2,
  output logic        aluSrc,
  output logic [31:0] aluIn,
  output logic [3:0]  aluOP,
  output logic [31:0] aluOut,
  output logic        zero,
  output logic        negative,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memload,
  output logic [31:0] writeData
);

  typedef enum logic [5:0] {
    OP_LUI = 6'd0, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_SLIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ERROR
  } op_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_PASSB
  } alu_e;

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  logic [31:0]   regs [32];
  logic [31:0]   dmem [DMEM_WORDS];
  op_e           op;
  alu_e          alu_op;
  logic [6:0]    opcode, f7;
  logic [2:0]    f3;
  logic          is_branch, is_store, reg_we, taken;
  logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]   pc_plus4, pc_imm, next_pc, ld_word, st_mask, st_data;
  logic [4:0]    lane_sh;
  logic [AW-1:0] dmem_addr;

  assign opcode  = instruction[6:0];
  assign f3      = instruction[14:12];
  assign f7      = instruction[31:25];
  assign regsel1 = instruction[19:15];
  assign regsel2 = instruction[24:20];
  assign w_reg   = instruction[11:7];
  assign imm     = instruction[31:12];
  assign cuOP    = op;
  assign aluOP   = alu_op;

  always_comb begin
    op = OP_ERROR;
    case (opcode)
      7'b0110111: op = OP_LUI;
      7'b0010111: op = OP_AUIPC;
      7'b1101111: op = OP_JAL;
      7'b1100111: if (f3 == 3'b000) op = OP_JALR;
      7'b1100011:
        case (f3)
          3'b000: op = OP_BEQ;
          3'b001: op = OP_BNE;
          3'b100: op = OP_BLT;
          3'b101: op = OP_BGE;
`ifdef BRANCH_UNSIGNED_EN
          3'b110: op = OP_BLTU;
          3'b111: op = OP_BGEU;
`endif
          default: op = OP_ERROR;
        endcase
      7'b0000011:
        case (f3)
          3'b000: op = OP_LB;
          3'b001: op = OP_LH;
          3'b010: op = OP_LW;
          3'b100: op = OP_LBU;
          3'b101: op = OP_LHU;
          default: op = OP_ERROR;
        endcase
      7'b0100011:
        case (f3)
          3'b000: op = OP_SB;
          3'b001: op = OP_SH;
          3'b010: op = OP_SW;
          default: op = OP_ERROR;
        endcase
      7'b0010011:
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: if (f7 == 7'b0000000) op = OP_SLLI;
          3'b101: begin
            if (f7 == 7'b0000000)      op = OP_SRLI;
            else if (f7 == 7'b0100000) op = OP_SRAI;
          end
          default: op = OP_ERROR;
        endcase
      7'b0110011:
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: op = OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = OP_SRL;
            3'b110: op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      op = OP_SUB;
          else if (f3 == 3'b101) op = OP_SRA;
        end
      default: op = OP_ERROR;
    endcase
  end

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};

  always_comb begin
    immOut = '0;
    case (op)
      OP_LUI, OP_AUIPC: immOut = imm_u;
      OP_JAL:           immOut = imm_j;
      OP_JALR, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: immOut = imm_i;
      OP_SLLI, OP_SRLI, OP_SRAI: immOut = {27'b0, instruction[24:20]};
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: immOut = imm_b;
      OP_SB, OP_SH, OP_SW: immOut = imm_s;
      default: immOut = '0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (op)
      OP_LUI:                             alu_op = ALU_PASSB;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE:     alu_op = ALU_SUB;
      OP_BLTU, OP_BGEU, OP_SLTIU, OP_SLTU: alu_op = ALU_SLTU;
      OP_SLTI, OP_SLT:                    alu_op = ALU_SLT;
      OP_XORI, OP_XOR:                    alu_op = ALU_XOR;
      OP_ORI, OP_OR:                      alu_op = ALU_OR;
      OP_ANDI, OP_AND:                    alu_op = ALU_AND;
      OP_SLLI, OP_SLL:                    alu_op = ALU_SLL;
      OP_SRLI, OP_SRL:                    alu_op = ALU_SRL;
      OP_SRAI, OP_SRA:                    alu_op = ALU_SRA;
      OP_SUB:                             alu_op = ALU_SUB;
      default:                            alu_op = ALU_ADD;
    endcase
  end

  assign is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE) ||
                     (op == OP_BLTU) || (op == OP_BGEU);
  assign is_store  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  assign memRead   = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) ||
                     (op == OP_LHU);
  assign memWrite  = is_store;
  assign reg_we    = !(is_branch || is_store || (op == OP_ERROR));
  assign aluSrc    = !(is_branch || (op == OP_ERROR) || ((op >= OP_ADD) && (op <= OP_AND)));

  assign regData1 = (regsel1 == 5'd0) ? '0 : regs[regsel1];
  assign regData2 = (regsel2 == 5'd0) ? '0 : regs[regsel2];
  assign aluIn    = aluSrc ? immOut : regData2;

  always_comb begin
    aluOut = '0;
    case (alu_op)
      ALU_ADD:   aluOut = regData1 + aluIn;
      ALU_SUB:   aluOut = regData1 - aluIn;
      ALU_SLL:   aluOut = regData1 << aluIn[4:0];
      ALU_SLT:   aluOut = {31'b0, $signed(regData1) < $signed(aluIn)};
      ALU_SLTU:  aluOut = {31'b0, regData1 < aluIn};
      ALU_XOR:   aluOut = regData1 ^ aluIn;
      ALU_SRL:   aluOut = regData1 >> aluIn[4:0];
      ALU_SRA:   aluOut = $unsigned($signed(regData1) >>> aluIn[4:0]);
      ALU_OR:    aluOut = regData1 | aluIn;
      ALU_AND:   aluOut = regData1 & aluIn;
      ALU_PASSB: aluOut = aluIn;
      default:   aluOut = '0;
    endcase
  end

  assign zero     = (aluOut == '0);
  assign negative = aluOut[31];

  // Byte lane from the low address bits; misaligned accesses simply shift, no trap.
  assign dmem_addr = aluOut[AW+1:2];
  assign lane_sh   = {aluOut[1:0], 3'b000};
  assign ld_word   = dmem[dmem_addr] >> lane_sh;

  always_comb begin
    memload = '0;
    case (op)
      OP_LB:   memload = {{24{ld_word[7]}}, ld_word[7:0]};
      OP_LH:   memload = {{16{ld_word[15]}}, ld_word[15:0]};
      OP_LW:   memload = ld_word;
      OP_LBU:  memload = {24'b0, ld_word[7:0]};
      OP_LHU:  memload = {16'b0, ld_word[15:0]};
      default: memload = '0;
    endcase
  end

  always_comb begin
    st_mask = '1;
    if (op == OP_SB)      st_mask = 32'h0000_00FF << lane_sh;
    else if (op == OP_SH) st_mask = 32'h0000_FFFF << lane_sh;
    else                  st_mask = '1 << lane_sh;
  end
  assign st_data = regData2 << lane_sh;

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (regData1 == regData2);
      OP_BNE:  taken = (regData1 != regData2);
      OP_BLT:  taken = ($signed(regData1) < $signed(regData2));
      OP_BGE:  taken = !($signed(regData1) < $signed(regData2));
      OP_BLTU: taken = (regData1 < regData2);
      OP_BGEU: taken = !(regData1 < regData2);
      default: taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign pc_imm   = pc + immOut;

  always_comb begin
    next_pc = pc_plus4;
    if (taken || (op == OP_JAL)) next_pc = pc_imm;
    else if (op == OP_JALR)      next_pc = {aluOut[31:1], 1'b0};
  end

  always_comb begin
    writeData = aluOut;
    if (memRead)                                 writeData = memload;
    else if ((op == OP_JAL) || (op == OP_JALR))  writeData = pc_plus4;
    else if (op == OP_AUIPC)                     writeData = pc_imm;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) pc <= '0;
    else       pc <= next_pc;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                               regs <= '{default: '0};
    else if (reg_we && (w_reg != 5'd0))      regs[w_reg] <= writeData;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)         dmem <= '{default: '0};
    else if (memWrite) dmem[dmem_addr] <= (dmem[dmem_addr] & ~st_mask) | (st_data & st_mask);
  end

endmodule

// File: tb/tb_rv32i_sc_core.sv
// Directed program for rv32i_sc_core; expected observations are queued per instruction and checked before retirement.
module tb_rv32i_sc_core;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [31:0] instruction = '0;
  logic [31:0] pc, immOut, regData1, regData2, aluIn, aluOut, memload, writeData;
  logic [5:0]  cuOP;
  logic [4:0]  regsel1, regsel2, w_reg;
  logic [19:0] imm;
  logic [3:0]  aluOP;
  logic        aluSrc, zero, negative, memRead, memWrite;

  rv32i_sc_core #(.DMEM_WORDS(64)) dut (
    .clk(clk), .nrst(nrst), .instruction(instruction), .pc(pc), .cuOP(cuOP),
    .regsel1(regsel1), .regsel2(regsel2), .w_reg(w_reg), .imm(imm), .immOut(immOut),
    .regData1(regData1), .regData2(regData2), .aluSrc(aluSrc), .aluIn(aluIn), .aluOP(aluOP),
    .aluOut(aluOut), .zero(zero), .negative(negative), .memRead(memRead), .memWrite(memWrite),
    .memload(memload), .writeData(writeData)
  );

  always #5 clk = ~clk;

  localparam int unsigned S_PC = 0, S_CUOP = 1, S_IMM = 2, S_RD1 = 3, S_RD2 = 4, S_ALUSRC = 5,
                          S_ALUIN = 6, S_ALUOP = 7, S_ALUOUT = 8, S_ZERO = 9, S_NEG = 10,
                          S_MEMRD = 11, S_MEMWR = 12, S_MEMLOAD = 13, S_WDATA = 14;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] cur_pc = '0;
  logic [31:0] jalr_ret = '0;

  function automatic logic [31:0] obs(input int unsigned sel);
    case (sel)
      S_PC:      return pc;
      S_CUOP:    return {26'b0, cuOP};
      S_IMM:     return immOut;
      S_RD1:     return regData1;
      S_RD2:     return regData2;
      S_ALUSRC:  return {31'b0, aluSrc};
      S_ALUIN:   return aluIn;
      S_ALUOP:   return {28'b0, aluOP};
      S_ALUOUT:  return aluOut;
      S_ZERO:    return {31'b0, zero};
      S_NEG:     return {31'b0, negative};
      S_MEMRD:   return {31'b0, memRead};
      S_MEMWR:   return {31'b0, memWrite};
      S_MEMLOAD: return memload;
      default:   return writeData;
    endcase
  endfunction

  function automatic logic [31:0] enc_i(input int im, input int rs1, input int f3, input int rd,
                                        input int op);
    logic [31:0] i_, a, f, d, o;
    i_ = im; a = rs1; f = f3; d = rd; o = op;
    return {i_[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    logic [31:0] s, b, a, f, d;
    s = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int im, input int rs2, input int rs1, input int f3);
    logic [31:0] i_, b, a, f;
    i_ = im; b = rs2; a = rs1; f = f3;
    return {i_[11:5], b[4:0], a[4:0], f[2:0], i_[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int im, input int rs2, input int rs1, input int f3);
    logic [31:0] i_, b, a, f;
    i_ = im; b = rs2; a = rs1; f = f3;
    return {i_[12], i_[10:5], b[4:0], a[4:0], f[2:0], i_[4:1], i_[11], 7'h63};
  endfunction

  function automatic void ev(input string tag, input int unsigned sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sbq.push_back(e);
  endfunction

  task automatic drive(input logic [31:0] ins);
    instruction = ins;
    cur_pc = exp_pc;
    ev("pc", S_PC, exp_pc);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic step();
    exp_t        e;
    logic [31:0] o;
    #2;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      vectors++;
      assert (o === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

  initial begin
    #1 nrst = 1'b0;
    drive(32'h0000_0000);
    exp_pc = '0;
    ev("rst_cuop", S_CUOP, 32'd38);
    ev("rst_rd1", S_RD1, 32'd0);
    step();
    nrst = 1'b1;
    exp_pc = '0;

    drive(32'h3e80_0093);                         // addi x1,x0,1000
    ev("addi_cuop", S_CUOP, 32'd18);
    ev("addi_imm", S_IMM, 32'd1000);
    ev("addi_alusrc", S_ALUSRC, 32'd1);
    ev("addi_aluout", S_ALUOUT, 32'd1000);
    ev("addi_wd", S_WDATA, 32'd1000);
    step();
    drive(32'h8300_0113);                         // addi x2,x0,-2000
    ev("addi_neg_wd", S_WDATA, 32'hFFFF_F830);
    ev("addi_neg_flag", S_NEG, 32'd1);
    step();
    drive(enc_i(1001, 0, 6, 3, 7'h13));           // ori x3,x0,1001
    ev("ori_cuop", S_CUOP, 32'd23);
    ev("ori_wd", S_WDATA, 32'd1001);
    step();
    drive(enc_r(0, 2, 1, 0, 0));                  // add x0,x1,x2
    ev("rd_x1", S_RD1, 32'd1000);
    ev("rd_x2", S_RD2, 32'hFFFF_F830);
    ev("add_alusrc", S_ALUSRC, 32'd0);
    ev("add_aluin", S_ALUIN, 32'hFFFF_F830);
    ev("add_aluout", S_ALUOUT, 32'hFFFF_FC18);
    step();
    drive(enc_r(0, 2, 1, 0, 4));                  // add x4 = -1000
    ev("add_cuop", S_CUOP, 32'd28);
    ev("add_wd", S_WDATA, 32'hFFFF_FC18);
    step();
    drive(enc_r(32, 2, 1, 0, 6));                 // sub x6 = 3000
    ev("sub_cuop", S_CUOP, 32'd29);
    ev("sub_aluop", S_ALUOP, 32'd1);
    ev("sub_wd", S_WDATA, 32'd3000);
    step();

    drive(enc_b(8, 1, 2, 1));                     // bne x2,x1,+8 taken
    ev("bne_cuop", S_CUOP, 32'd5);
    ev("bne_aluop", S_ALUOP, 32'd1);
    ev("bne_imm", S_IMM, 32'd8);
    ev("bne_aluout", S_ALUOUT, 32'hFFFF_F448);
    exp_pc = cur_pc + 32'd8;
    step();
    drive(enc_b(8, 3, 1, 0));                     // beq x1,x3 not taken
    ev("beq_nt_cuop", S_CUOP, 32'd4);
    ev("beq_nt_zero", S_ZERO, 32'd0);
    ev("beq_nt_aluout", S_ALUOUT, 32'hFFFF_FFFF);
    step();
    drive(enc_b(12, 3, 3, 0));                    // beq x3,x3,+12 taken
    ev("beq_t_zero", S_ZERO, 32'd1);
    exp_pc = cur_pc + 32'd12;
    step();
    drive(enc_b(12, 1, 4, 4));                    // blt x4,x1,+12 taken
    ev("blt_cuop", S_CUOP, 32'd6);
    ev("blt_neg", S_NEG, 32'd1);
    exp_pc = cur_pc + 32'd12;
    step();
    drive(enc_b(12, 1, 4, 5));                    // bge x4,x1 not taken
    ev("bge_cuop", S_CUOP, 32'd7);
    step();
    drive(enc_b(8, 1, 4, 6));                     // bltu x4,x1 not taken
`ifdef BRANCH_UNSIGNED_EN
    ev("bltu_cuop", S_CUOP, 32'd8);
    ev("bltu_aluop", S_ALUOP, 32'd4);
    ev("bltu_zero", S_ZERO, 32'd1);
`else
    ev("bltu_cuop", S_CUOP, 32'd38);
`endif
    step();
    drive(enc_b(8, 1, 4, 7));                     // bgeu x4,x1 taken when enabled
`ifdef BRANCH_UNSIGNED_EN
    ev("bgeu_cuop", S_CUOP, 32'd9);
    exp_pc = cur_pc + 32'd8;
`else
    ev("bgeu_cuop", S_CUOP, 32'd38);
`endif
    step();

    drive(32'h7d00_00ef);                         // jal x1,2000
    ev("jal_cuop", S_CUOP, 32'd2);
    ev("jal_wd", S_WDATA, cur_pc + 32'd4);
    exp_pc = cur_pc + 32'd2000;
    step();
    drive(32'h007d_00b7);                         // lui x1,0x7d0
    ev("lui_cuop", S_CUOP, 32'd0);
    ev("lui_aluop", S_ALUOP, 32'd10);
    ev("lui_wd", S_WDATA, 32'h007D_0000);
    step();
    drive(32'h0000_1297);                         // auipc x5,1
    ev("auipc_cuop", S_CUOP, 32'd1);
    ev("auipc_wd", S_WDATA, cur_pc + 32'h1000);
    step();
    drive(enc_i(32'h101, 0, 0, 6, 7'h67));        // jalr x6,0x101(x0)
    ev("jalr_cuop", S_CUOP, 32'd3);
    ev("jalr_wd", S_WDATA, cur_pc + 32'd4);
    jalr_ret = cur_pc + 32'd4;
    exp_pc = 32'h100;
    step();
    drive(enc_r(0, 6, 1, 0, 0));
    ev("rd_lui_x1", S_RD1, 32'h007D_0000);
    ev("rd_jalr_x6", S_RD2, jalr_ret);
    step();

    drive(enc_i(32'hAA, 0, 0, 3, 7'h13));
    step();
    drive(enc_i(-255, 0, 0, 5, 7'h13));
    ev("x5_wd", S_WDATA, 32'hFFFF_FF01);
    step();
    drive(enc_i(3, 0, 0, 1, 7'h13));
    step();
    drive(enc_i(5, 3, 1, 8, 7'h13));              // slli x8,x3,5
    ev("slli_cuop", S_CUOP, 32'd25);
    ev("slli_wd", S_WDATA, 32'h0000_1540);
    step();
    drive(enc_i(32'h405, 3, 5, 9, 7'h13));        // srai x9,x3,5
    ev("srai_cuop", S_CUOP, 32'd27);
    ev("srai_wd", S_WDATA, 32'd5);
    step();
    drive(enc_i(32'h404, 5, 5, 10, 7'h13));       // srai x10,x5,4
    ev("srai_neg_wd", S_WDATA, 32'hFFFF_FFF0);
    step();
    drive(enc_i(4, 5, 5, 11, 7'h13));             // srli x11,x5,4
    ev("srli_cuop", S_CUOP, 32'd26);
    ev("srli_wd", S_WDATA, 32'h0FFF_FFF0);
    step();
    drive(enc_r(0, 5, 3, 3, 16));                 // sltu x16,x3,x5
    ev("sltu_cuop", S_CUOP, 32'd32);
    ev("sltu_wd", S_WDATA, 32'd1);
    step();
    drive(enc_r(0, 3, 5, 2, 12));                 // slt x12,x5,x3
    ev("slt_wd", S_WDATA, 32'd1);
    step();
    drive(enc_r(32, 1, 3, 5, 18));                // sra x18,x3,x1
    ev("sra_cuop", S_CUOP, 32'd35);
    ev("sra_wd", S_WDATA, 32'h15);
    step();

    drive(enc_s(8, 5, 0, 2));                     // sw x5,8(x0)
    ev("sw_cuop", S_CUOP, 32'd17);
    ev("sw_memwr", S_MEMWR, 32'd1);
    ev("sw_memrd", S_MEMRD, 32'd0);
    ev("sw_aluout", S_ALUOUT, 32'd8);
    ev("sw_memload", S_MEMLOAD, 32'd0);
    step();
    drive(enc_i(8, 0, 2, 13, 7'h03));             // lw x13,8(x0)
    ev("lw_cuop", S_CUOP, 32'd12);
    ev("lw_memrd", S_MEMRD, 32'd1);
    ev("lw_memload", S_MEMLOAD, 32'hFFFF_FF01);
    ev("lw_wd", S_WDATA, 32'hFFFF_FF01);
    step();
    drive(enc_i(9, 0, 0, 14, 7'h03));             // lb x14,9(x0)
    ev("lb_wd", S_WDATA, 32'hFFFF_FFFF);
    step();
    drive(enc_i(8, 0, 4, 15, 7'h03));             // lbu x15,8(x0)
    ev("lbu_wd", S_WDATA, 32'h0000_0001);
    step();
    drive(enc_i(10, 0, 5, 17, 7'h03));            // lhu x17,10(x0)
    ev("lhu_wd", S_WDATA, 32'h0000_FFFF);
    step();
    drive(enc_s(9, 3, 0, 0));                     // sb x3,9(x0)
    ev("sb_cuop", S_CUOP, 32'd15);
    step();
    drive(enc_i(8, 0, 2, 19, 7'h03));
    ev("lw_after_sb", S_MEMLOAD, 32'hFFFF_AA01);
    step();
    drive(enc_s(14, 3, 0, 1));                    // sh x3,14(x0)
    ev("sh_cuop", S_CUOP, 32'd16);
    step();
    drive(enc_i(14, 0, 1, 20, 7'h03));            // lh x20,14(x0)
    ev("lh_cuop", S_CUOP, 32'd11);
    ev("lh_wd", S_WDATA, 32'h0000_00AA);
    step();
    drive(enc_i(12, 0, 2, 21, 7'h03));
    ev("lw_after_sh", S_MEMLOAD, 32'h00AA_0000);
    step();
    drive(enc_i(264, 0, 2, 21, 7'h03));           // address wraps onto word 2
    ev("lw_wrap", S_MEMLOAD, 32'hFFFF_AA01);
    step();

    drive(enc_i(5, 0, 0, 0, 7'h13));              // addi x0,x0,5
    ev("x0_wd", S_WDATA, 32'd5);
    step();
    drive(enc_r(0, 0, 0, 0, 0));
    ev("x0_read", S_RD1, 32'd0);
    step();
    drive(32'h0000_0000);
    ev("err_zero_cuop", S_CUOP, 32'd38);
    step();
    drive(enc_r(1, 3, 3, 0, 1));                  // bad funct7, rd=x1
    ev("err_f7_cuop", S_CUOP, 32'd38);
    step();
    drive(enc_r(0, 3, 1, 0, 0));
    ev("err_nowrite_x1", S_RD1, 32'd3);
    ev("rd_x3", S_RD2, 32'h0000_00AA);
    step();

    nrst = 1'b0;
    exp_pc = '0;
    drive(enc_r(0, 3, 1, 0, 0));
    ev("midrst_x1", S_RD1, 32'd0);
    ev("midrst_x3", S_RD2, 32'd0);
    step();
    nrst = 1'b1;
    exp_pc = '0;
    drive(enc_i(7, 0, 0, 1, 7'h13));
    ev("post_rst_wd", S_WDATA, 32'd7);
    step();
    drive(enc_r(0, 0, 1, 0, 0));
    ev("post_rst_x1", S_RD1, 32'd7);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
